// File: rtl/wb_queue_if.sv
// wb_queue_if: bundles the writeback-queue bus signals.
//   ld_*   : load-unit result handshake (valid/ready, rd, we, data)
//   alu_*  : ALU result handshake (valid/ready, rd, we, data)
//   rf_*   : register-file write port driven from the queue head
//   pending: per-register "write still queued" mask for decode stalls
//   count  : queue occupancy
// Modports: slave = the queue itself, master = producers/consumers around it.
interface wb_queue_if #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic              ld_valid;
   logic              ld_ready;
   logic [2:0]        ld_rd;
   logic [1:0]        ld_we;
   logic [DATA_W-1:0] ld_data;

   logic              alu_valid;
   logic              alu_ready;
   logic [2:0]        alu_rd;
   logic [1:0]        alu_we;
   logic [DATA_W-1:0] alu_data;

   logic [1:0]        rf_we;
   logic [2:0]        rf_wenc;
   logic [DATA_W-1:0] rf_wdata;

   logic [7:0]        pending;
   logic [CW-1:0]     count;

   modport slave (
      input  ld_valid, ld_rd, ld_we, ld_data,
      input  alu_valid, alu_rd, alu_we, alu_data,
      output ld_ready, alu_ready,
      output rf_we, rf_wenc, rf_wdata, pending, count
   );

   modport master (
      output ld_valid, ld_rd, ld_we, ld_data,
      output alu_valid, alu_rd, alu_we, alu_data,
      input  ld_ready, alu_ready,
      input  rf_we, rf_wenc, rf_wdata, pending, count
   );
endinterface

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback FIFO in front of the 8x32 register file.
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset, empties the queue
//   bus   : wb_queue_if.slave -- load/ALU result handshakes in, register-file
//           write port, pending mask and occupancy out.
// Loads win over the ALU when only one slot is free; when both are accepted
// together the load entry is enqueued first. The head entry is presented on
// rf_* for a whole cycle and pops unconditionally at the next posedge.
module wb_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32
) (
   input  logic       clk,
   input  logic       reset,
   wb_queue_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [1:0]        q_we   [DEPTH];
   logic [2:0]        q_rd   [DEPTH];
   logic [DATA_W-1:0] q_data [DEPTH];

   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] alu_slot;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic [CW-1:0] free;

   logic ld_ready_c;
   logic alu_ready_c;
   logic enq_ld;
   logic enq_alu;
   logic deq;
   logic [7:0] pending_c;

   // Free space is based on the registered count only; the drain happening
   // this cycle is deliberately not credited.
   assign free = CW'(DEPTH) - cnt;
   assign deq  = (cnt != '0);

   assign ld_ready_c  = !reset && (free >= CW'(1));
   assign alu_ready_c = !reset && ((free >= CW'(2)) ||
                                   ((free == CW'(1)) && !bus.ld_valid));

   // A handshake with no halfword enables completes but stores nothing.
   assign enq_ld  = bus.ld_valid  && ld_ready_c  && (bus.ld_we  != 2'b00);
   assign enq_alu = bus.alu_valid && alu_ready_c && (bus.alu_we != 2'b00);

   // ALU entry lands behind the load entry when both enqueue together.
   assign alu_slot = wr_ptr + AW'(enq_ld);

   assign cnt_next = cnt + CW'(enq_ld) + CW'(enq_alu) - CW'(deq);

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (enq_ld) begin
            q_we[wr_ptr]   <= bus.ld_we;
            q_rd[wr_ptr]   <= bus.ld_rd;
            q_data[wr_ptr] <= bus.ld_data;
         end
         if (enq_alu) begin
            q_we[alu_slot]   <= bus.alu_we;
            q_rd[alu_slot]   <= bus.alu_rd;
            q_data[alu_slot] <= bus.alu_data;
         end
         wr_ptr <= wr_ptr + AW'(enq_ld) + AW'(enq_alu);
         if (deq) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         cnt <= cnt_next;
      end
   end

   // Pending mask: OR of one-hot destinations over occupied slots, head included.
   always_comb begin
      pending_c = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (CW'(i) < cnt) begin
            pending_c[q_rd[rd_ptr + AW'(i)]] = 1'b1;
         end
      end
   end

   assign bus.ld_ready  = ld_ready_c;
   assign bus.alu_ready = alu_ready_c;
   assign bus.rf_we     = deq ? q_we[rd_ptr]   : 2'b00;
   assign bus.rf_wenc   = deq ? q_rd[rd_ptr]   : 3'd0;
   assign bus.rf_wdata  = deq ? q_data[rd_ptr] : '0;
   assign bus.pending   = pending_c;
   assign bus.count     = cnt;
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: scoreboard bench for wb_queue. The driver decides acceptance
// from the queue rules (free slots, load priority) and pushes accepted
// entries into an expected queue; the monitor samples on negedge, checks
// occupancy/readies/pending against that queue and pops one entry per
// register-file write it observes.
module tb_wb_queue;
   localparam int unsigned DEPTH = 4;

   typedef struct {
      logic [1:0]  we;
      logic [2:0]  rd;
      logic [31:0] data;
   } entry_t;

   logic clk = 1'b0;
   logic reset;

   wb_queue_if #(.DEPTH(DEPTH), .DATA_W(32)) bus ();

   wb_queue #(.DEPTH(DEPTH), .DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   entry_t exp_q[$];
   bit     exp_ld_ready;
   bit     exp_alu_ready;
   int     checks = 0;
   int     errors = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // One clock of stimulus; the model is updated at the posedge that samples it.
   task automatic cycle(input logic r,
                        input logic lv, input logic [2:0] lrd, input logic [1:0] lwe, input logic [31:0] ld,
                        input logic av, input logic [2:0] ard, input logic [1:0] awe, input logic [31:0] ad);
      int unsigned fr;
      bit lr, ar;
      reset         = r;
      bus.ld_valid  = lv;  bus.ld_rd  = lrd; bus.ld_we  = lwe; bus.ld_data  = ld;
      bus.alu_valid = av;  bus.alu_rd = ard; bus.alu_we = awe; bus.alu_data = ad;
      fr = DEPTH - exp_q.size();
      lr = !r && (fr >= 1);
      ar = !r && (fr >= 2 || (fr == 1 && !lv));
      exp_ld_ready  = lr;
      exp_alu_ready = ar;
      @(posedge clk);
      if (r) begin
         exp_q.delete();
      end else begin
         if (lv && lr && lwe != 2'b00) exp_q.push_back('{we: lwe, rd: lrd, data: ld});
         if (av && ar && awe != 2'b00) exp_q.push_back('{we: awe, rd: ard, data: ad});
      end
      #2;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0, 3'd0, 2'd0, 32'd0);
   endtask

   // Monitor
   initial begin
      entry_t     e;
      logic [7:0] pm;
      @(posedge clk);
      forever begin
         @(negedge clk);
         chk("count", 32'(bus.count), 32'(exp_q.size()));
         chk("ld_ready", 32'(bus.ld_ready), 32'(exp_ld_ready));
         chk("alu_ready", 32'(bus.alu_ready), 32'(exp_alu_ready));
         pm = '0;
         foreach (exp_q[i]) pm[exp_q[i].rd] = 1'b1;
         chk("pending", 32'(bus.pending), 32'(pm));
         if (bus.rf_we != 2'b00) begin
            if (exp_q.size() == 0) begin
               chk("spurious_rf_we", 32'(bus.rf_we), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("rf_we", 32'(bus.rf_we), 32'(e.we));
               chk("rf_wenc", 32'(bus.rf_wenc), 32'(e.rd));
               chk("rf_wdata", bus.rf_wdata, e.data);
            end
         end else begin
            chk("idle_queue_empty", 32'(exp_q.size()), 32'd0);
            chk("idle_rf_wenc", 32'(bus.rf_wenc), 32'd0);
            chk("idle_rf_wdata", bus.rf_wdata, 32'd0);
         end
      end
   end

   // Driver
   initial begin
      logic [31:0] k;
      // Reset held two cycles with both valids asserted
      cycle(1'b1, 1'b1, 3'd1, 2'b11, 32'h1, 1'b1, 3'd2, 2'b11, 32'h2);
      cycle(1'b1, 1'b1, 3'd1, 2'b11, 32'h1, 1'b1, 3'd2, 2'b11, 32'h2);
      idle(2);
      // Single ALU write
      cycle(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b1, 3'd3, 2'b11, 32'hDEADBEEF);
      idle(3);
      // Dual enqueue: load drains first
      cycle(1'b0, 1'b1, 3'd1, 2'b11, 32'h1111_1111, 1'b1, 3'd2, 2'b11, 32'h2222_2222);
      idle(4);
      // Fill from empty with both valid every cycle
      for (int i = 0; i < 8; i++) begin
         k = 32'(i);
         cycle(1'b0, 1'b1, k[2:0], 2'b11, 32'hA000_0000 | k, 1'b1, 3'(7 - i), 2'b10, 32'hB000_0000 | k);
      end
      idle(6);
      // Halfword and dropped (we=00) ALU writes
      cycle(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b1, 3'd5, 2'b01, 32'hABCD_1234);
      idle(2);
      cycle(1'b0, 1'b0, 3'd0, 2'd0, 32'd0, 1'b1, 3'd6, 2'b00, 32'h5555_5555);
      cycle(1'b0, 1'b1, 3'd4, 2'b00, 32'h6666_6666, 1'b0, 3'd0, 2'd0, 32'd0);
      idle(2);
      // Reset mid-stream with entries queued
      cycle(1'b0, 1'b1, 3'd1, 2'b11, 32'hC1, 1'b1, 3'd2, 2'b11, 32'hC2);
      cycle(1'b0, 1'b1, 3'd3, 2'b11, 32'hC3, 1'b1, 3'd4, 2'b11, 32'hC4);
      cycle(1'b1, 1'b0, 3'd0, 2'd0, 32'd0, 1'b0, 3'd0, 2'd0, 32'd0);
      idle(4);
      // Randomized traffic with occasional reset
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 99) == 0,
               1'($urandom_range(0, 1)), 3'($urandom), 2'($urandom), $urandom,
               1'($urandom_range(0, 1)), 3'($urandom), 2'($urandom), $urandom);
      end
      idle(DEPTH + 3);
      chk("final_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
